// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I architectural constants
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

endpackage : riscv_pkg

// File: rtl/reg_file.sv
// rtl/reg_file.sv - RV32I integer register file, two async reads, one sync write, x0 hardwired to zero
module reg_file
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Architectural register storage; the name is probed hierarchically.
  logic [DATA_W-1:0] register [0:DEPTH-1];

  // Reset clears every entry and wins over a same-cycle write; x0 is never written.
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        register[i] <= '0;
      end
    end else if (WE3 && (A3 != '0)) begin
      register[A3] <= WD3;
    end
  end

  // Reads are combinational with no bypass: a same-address write shows up only after the edge.
  assign RD1 = register[A1];
  assign RD2 = register[A2];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

  logic        clk;
  logic        areset;
  logic        WE3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int pass_cnt;
  int total_cnt;

  reg_file dut (
    .clk    (clk),
    .areset (areset),
    .WE3    (WE3),
    .A1     (A1),
    .A2     (A2),
    .A3     (A3),
    .WD3    (WD3),
    .RD1    (RD1),
    .RD2    (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    areset = 1'b0;
    WE3    = 1'b1;
    A3     = a;
    WD3    = d;
    @(posedge clk);
    #1;
    WE3    = 1'b0;
  endtask

  function automatic logic [31:0] pattern(input int i);
    logic [31:0] p;
    p = (32'h0101_0101 * i) ^ 32'hC3A5_0000;
    return p;
  endfunction

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    areset = 1'b1;
    WE3    = 1'b0;
    A1     = '0;
    A2     = '0;
    A3     = '0;
    WD3    = '0;

    // 1. Reset for two edges
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("reset_reg%0d", i), dut.register[i], 32'h0);
    end
    A1 = 5'd7;
    A2 = 5'd7;
    #1;
    check("reset_rd1", RD1, 32'h0);
    check("reset_rd2", RD2, 32'h0);

    // 2. Write then combinational read
    write_reg(5'd4, 32'hDEAD_BEEF);
    check("wr_reg4", dut.register[4], 32'hDEAD_BEEF);
    A1 = 5'd4;
    A2 = 5'd4;
    #1;
    check("rd1_reg4", RD1, 32'hDEAD_BEEF);
    check("rd2_reg4", RD2, 32'hDEAD_BEEF);

    // 3. x0 write ignored
    write_reg(5'd0, 32'hFFFF_FFFF);
    check("x0_reg0", dut.register[0], 32'h0);
    A1 = 5'd0;
    #1;
    check("x0_rd1", RD1, 32'h0);

    // 4. WE3=0 holds contents
    @(negedge clk);
    WE3 = 1'b0;
    A3  = 5'd4;
    WD3 = 32'h1234_5678;
    @(posedge clk);
    #1;
    check("hold_reg4", dut.register[4], 32'hDEAD_BEEF);

    // 5. Dual port and read-during-write
    write_reg(5'd5,  32'hA5A5_A5A5);
    write_reg(5'd31, 32'h5A5A_5A5A);
    A1 = 5'd5;
    A2 = 5'd31;
    #1;
    check("dual_rd1", RD1, 32'hA5A5_A5A5);
    check("dual_rd2", RD2, 32'h5A5A_5A5A);
    @(negedge clk);
    WE3 = 1'b1;
    A3  = 5'd5;
    WD3 = 32'h0000_0001;
    #1;
    check("rdw_before", RD1, 32'hA5A5_A5A5);
    check("rdw_other", RD2, 32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    WE3 = 1'b0;
    check("rdw_after", RD1, 32'h0000_0001);

    // Every address holds its own value on both ports
    for (int i = 1; i < 32; i++) begin
      write_reg(i[4:0], pattern(i));
    end
    for (int i = 0; i < 32; i++) begin
      A1 = i[4:0];
      A2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_rd1_%0d", i), RD1, (i == 0) ? 32'h0 : pattern(i));
      check($sformatf("sweep_rd2_%0d", i), RD2, (i == 31) ? 32'h0 : pattern(31 - i));
    end

    // 6. Reset beats a same-cycle write
    @(negedge clk);
    areset = 1'b1;
    WE3    = 1'b1;
    A3     = 5'd9;
    WD3    = 32'h0000_0077;
    @(posedge clk);
    #1;
    areset = 1'b0;
    WE3    = 1'b0;
    check("rst_wins_reg9", dut.register[9], 32'h0);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("rst2_reg%0d", i), dut.register[i], 32'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_reg_file
